// File: rtl/level_sequencer.sv
// Row/level sequencer for a key-matching rhythm game.
// Define LEVEL_SEQ_STREAK_BONUS_EN to award +5 for a miss-free level.
module level_sequencer #(
  parameter int WINDOW     = 4,
  parameter int LIVES      = 3,
  parameter int NUM_LEVELS = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic        tick,
  input  logic [11:0] keys_in,
  input  logic [71:0] rows_in,
  output logic        level_next,
  output logic        level_clear,
  output logic [2:0]  current_row,
  output logic [11:0] target,
  output logic        hit,
  output logic        miss,
  output logic [7:0]  score,
  output logic [1:0]  lives,
  output logic        busy,
  output logic        game_over,
  output logic        win
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOAD      = 3'd1;
  localparam logic [2:0] SHOW      = 3'd2;
  localparam logic [2:0] NEXT      = 3'd3;
  localparam logic [2:0] LVL_DONE  = 3'd4;
  localparam logic [2:0] GAME_OVER = 3'd5;
  localparam logic [2:0] WIN       = 3'd6;

  localparam logic [3:0] TICKS      = 4'(WINDOW);
  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [4:0] LEVELS     = 5'(NUM_LEVELS);

  logic [2:0]  state;
  logic        load_cnt;
  logic [3:0]  tcnt;
  logic [4:0]  level;
  logic [11:0] row_cur;
  logic [11:0] row_nxt;
  logic [7:0]  score_hit;

  function automatic logic [11:0] sel_row(
    input logic [2:0]  idx,
    input logic [71:0] rows
  );
    case (idx)
      3'd0:    return rows[11:0];
      3'd1:    return rows[23:12];
      3'd2:    return rows[35:24];
      3'd3:    return rows[47:36];
      3'd4:    return rows[59:48];
      3'd5:    return rows[71:60];
      default: return 12'h000;
    endcase
  endfunction

  assign row_cur   = sel_row(current_row, rows_in);
  assign row_nxt   = sel_row(current_row + 3'd1, rows_in);
  assign score_hit = (score == 8'hFF) ? score : score + 8'd1;

  assign busy      = !(state == IDLE || state == GAME_OVER
                       || state == WIN);
  assign game_over = (state == GAME_OVER);
  assign win       = (state == WIN);

`ifdef LEVEL_SEQ_STREAK_BONUS_EN
  logic       clean;
  logic [7:0] score_bonus;
  assign score_bonus = (score > 8'd250) ? 8'hFF : score + 8'd5;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= IDLE;
      load_cnt    <= 1'b0;
      tcnt        <= 4'd0;
      level       <= 5'd0;
      current_row <= 3'd0;
      target      <= 12'h000;
      score       <= 8'd0;
      lives       <= LIVES_INIT;
      hit         <= 1'b0;
      miss        <= 1'b0;
      level_next  <= 1'b0;
      level_clear <= 1'b0;
`ifdef LEVEL_SEQ_STREAK_BONUS_EN
      clean       <= 1'b1;
`endif
    end else begin
      hit         <= 1'b0;
      miss        <= 1'b0;
      level_next  <= 1'b0;
      level_clear <= 1'b0;
      case (state)
        IDLE, GAME_OVER, WIN: begin
          if (start) begin
            level_clear <= 1'b1;
            score       <= 8'd0;
            lives       <= LIVES_INIT;
            level       <= 5'd0;
            current_row <= 3'd0;
            load_cnt    <= 1'b0;
            state       <= LOAD;
`ifdef LEVEL_SEQ_STREAK_BONUS_EN
            clean       <= 1'b1;
`endif
          end
        end
        LOAD: begin
          if (load_cnt) begin
            state       <= SHOW;
            current_row <= 3'd0;
            tcnt        <= 4'd0;
            target      <= sel_row(3'd0, rows_in);
          end else begin
            load_cnt <= 1'b1;
          end
        end
        SHOW: begin
          target <= row_cur;
          // a hit takes priority over an expiring tick
          if (target != 12'h000 && keys_in == target) begin
            hit    <= 1'b1;
            score  <= score_hit;
            target <= 12'h000;
            state  <= NEXT;
          end else if (tick) begin
            if (target == 12'h000) begin
              state <= NEXT;
            end else if (tcnt + 4'd1 == TICKS) begin
              miss   <= 1'b1;
              lives  <= lives - 2'd1;
              target <= 12'h000;
              state  <= (lives == 2'd1) ? GAME_OVER : NEXT;
`ifdef LEVEL_SEQ_STREAK_BONUS_EN
              clean  <= 1'b0;
`endif
            end else begin
              tcnt <= tcnt + 4'd1;
            end
          end
        end
        NEXT: begin
          if (current_row == 3'd5) begin
            level_next <= 1'b1;
            state      <= LVL_DONE;
          end else begin
            current_row <= current_row + 3'd1;
            tcnt        <= 4'd0;
            target      <= row_nxt;
            state       <= SHOW;
          end
        end
        LVL_DONE: begin
          level <= level + 5'd1;
`ifdef LEVEL_SEQ_STREAK_BONUS_EN
          if (clean) score <= score_bonus;
          clean <= 1'b1;
`endif
          if (level + 5'd1 == LEVELS) begin
            state <= WIN;
          end else begin
            load_cnt <= 1'b0;
            state    <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
